// File: rtl/mem_burst_arbiter.sv
// Burst arbiter sharing one memory port between the I$ refill engine and the D$ engine.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ownership on ties instead of fixed D$ priority.
module mem_burst_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rlast,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [LEN_WIDTH-1:0]  d_len,
  output logic                  d_gnt,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_wvalid,
  output logic                  d_wready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rlast,
  output logic                  d_bdone,
  output logic                  m_req,
  output logic                  m_we,
  output logic [31:0]           m_addr,
  output logic [LEN_WIDTH-1:0]  m_len,
  input  logic                  m_ack,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  output logic                  m_wlast,
  input  logic                  m_wready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_bvalid
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCmd   = 3'd1;
  localparam logic [2:0] StRdata = 3'd2;
  localparam logic [2:0] StWdata = 3'd3;
  localparam logic [2:0] StWresp = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 owner_q, owner_d;  // 1: D$ owns the burst, 0: I$
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 grant_dcache;
  logic                 wlast;

  assign wlast = (wcnt_q == len_q);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (i_req && d_req) begin
      grant_dcache = ~last_owner_q;
    end else begin
      grant_dcache = d_req;
    end
    if ((state_q == StIdle) && (i_req || d_req)) begin
      last_owner_d = grant_dcache;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // D$ wins every tie.
  assign grant_dcache = d_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          owner_d = grant_dcache;
          we_d    = grant_dcache & d_we;
          addr_d  = grant_dcache ? d_addr : i_addr;
          len_d   = grant_dcache ? d_len : i_len;
          wcnt_d  = '0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (m_ack) begin
          state_d = we_q ? StWdata : StRdata;
        end
      end
      StRdata: begin
        if (m_rvalid && m_rlast) begin
          state_d = StIdle;
        end
      end
      StWdata: begin
        if (d_wvalid && m_wready) begin
          if (wlast) begin
            wcnt_d  = '0;
            state_d = StWresp;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StWresp: begin
        if (m_bvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode from state so an asynchronous reset silences them at once.
  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_rlast  = 1'b0;
    d_gnt    = 1'b0;
    d_wready = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_rlast  = 1'b0;
    d_bdone  = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_len    = '0;
    m_wdata  = '0;
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
    case (state_q)
      StCmd: begin
        m_req  = 1'b1;
        m_we   = we_q;
        m_addr = addr_q;
        m_len  = len_q;
        i_gnt  = m_ack & ~owner_q;
        d_gnt  = m_ack & owner_q;
      end
      StRdata: begin
        if (owner_q) begin
          d_rvalid = m_rvalid;
          d_rdata  = m_rdata;
          d_rlast  = m_rvalid & m_rlast;
        end else begin
          i_rvalid = m_rvalid;
          i_rdata  = m_rdata;
          i_rlast  = m_rvalid & m_rlast;
        end
      end
      StWdata: begin
        m_wvalid = d_wvalid;
        m_wdata  = d_wdata;
        m_wlast  = wlast;
        d_wready = m_wready;
      end
      StWresp: begin
        d_bdone = m_bvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: directed tie table, hand sequences and a
// randomized burst loop checked against a transaction-level arbitration/beat model.
module tb_mem_burst_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk, rst;
  logic          i_req, i_gnt, i_rvalid, i_rlast;
  logic [31:0]   i_addr;
  logic [LW-1:0] i_len;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_wvalid, d_wready, d_rvalid, d_rlast, d_bdone;
  logic [31:0]   d_addr;
  logic [LW-1:0] d_len;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack, m_wvalid, m_wlast, m_wready;
  logic          m_rvalid, m_rlast, m_bvalid;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_len;
  logic [DW-1:0] m_wdata, m_rdata;

  mem_burst_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
    .d_wdata(d_wdata), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_bdone(d_bdone),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_bvalid(m_bvalid)
  );

  logic any_out;
  assign any_out = |{i_gnt, i_rvalid, i_rdata, i_rlast, d_gnt, d_wready, d_rvalid, d_rdata,
                     d_rlast, d_bdone, m_req, m_we, m_addr, m_len, m_wdata, m_wvalid, m_wlast};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  bit  i_pend = 0;
  bit  d_pend = 0;
  bit  model_last_d = 1;   // previous burst owner; D$ after reset
  logic [7:0] wr_pat = 8'b0001_1101;

  typedef struct {
    bit         raise_i;
    bit         raise_d;
    bit         d_we;
    logic [7:0] len;
    bit         exp_d;
  } vec_t;
  vec_t vecs[4];
  int   n_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_i(input logic [7:0] len);
    i_req  = 1'b1;
    i_addr = 32'h0010_0000 | ($urandom & 32'h0000_FFFC);
    i_len  = len;
    i_pend = 1'b1;
  endtask

  task automatic raise_d(input bit we, input logic [7:0] len);
    d_req  = 1'b1;
    d_we   = we;
    d_addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    d_len  = len;
    d_pend = 1'b1;
  endtask

  function automatic bit exp_winner_d();
    if (!i_pend) return 1'b1;
    if (!d_pend) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !model_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Serve one burst for the expected owner, from the IDLE cycle with requests already driven.
  task automatic run_burst(input bit own_d, input int ack_dly, input bit drct);
    logic [31:0] ea;
    logic [7:0]  el;
    bit          ew;
    int          n, b, k;
    ea = own_d ? d_addr : i_addr;
    el = own_d ? d_len : i_len;
    ew = own_d & d_we;
    n  = 0;
    #1;
    while (!m_req && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk("cmd_wait", m_req, 1);
    if (!m_req) return;
    for (int c = 0; c <= ack_dly; c++) begin
      m_ack = (c == ack_dly);
      #1;
      chk("cmd_req", m_req, 1);
      chk("cmd_addr", m_addr, ea);
      chk("cmd_len", m_len, el);
      chk("cmd_we", m_we, ew);
      chk("gnt_i", i_gnt, m_ack && !own_d);
      chk("gnt_d", d_gnt, m_ack && own_d);
      tick();
    end
    m_ack = 1'b0;
    if (own_d) begin
      d_req = 1'b0; d_pend = 1'b0; d_addr = $urandom; d_len = LW'($urandom); d_we = 1'($urandom);
    end else begin
      i_req = 1'b0; i_pend = 1'b0; i_addr = $urandom; i_len = LW'($urandom);
    end
    #1;
    chk("cmd_drop", m_req, 0);
    b = 0;
    n = 0;
    if (!ew) begin
      while (b <= int'(el) && n < 200) begin
        m_rvalid = drct ? 1'b1 : ($urandom_range(0, 2) != 0);
        m_rdata  = $urandom;
        m_rlast  = m_rvalid && (b == int'(el));
        #1;
        chk("rv_owner", own_d ? d_rvalid : i_rvalid, m_rvalid);
        chk("rv_other", own_d ? i_rvalid : d_rvalid, 0);
        if (m_rvalid) begin
          chk("rdata", own_d ? d_rdata : i_rdata, m_rdata);
          chk("rlast", own_d ? d_rlast : i_rlast, m_rlast);
          b++;
        end
        tick();
        n++;
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end else begin
      while (b <= int'(el) && n < 200) begin
        d_wvalid = drct ? 1'b1 : 1'($urandom_range(0, 1));
        d_wdata  = $urandom;
        m_wready = drct ? wr_pat[n % 8] : 1'($urandom_range(0, 1));
        #1;
        chk("wvalid", m_wvalid, d_wvalid);
        chk("wready", d_wready, m_wready);
        chk("bdone_early", d_bdone, 0);
        if (d_wvalid) begin
          chk("wdata", m_wdata, d_wdata);
          chk("wlast", m_wlast, b == int'(el));
        end
        if (d_wvalid && m_wready) b++;
        tick();
        n++;
      end
      d_wvalid = 1'b0;
      m_wready = 1'b0;
      k = drct ? 0 : $urandom_range(0, 3);
      for (int w = 0; w < k; w++) begin
        #1;
        chk("bdone_wait", d_bdone, 0);
        tick();
      end
      m_bvalid = 1'b1;
      #1;
      chk("bdone", d_bdone, 1);
      tick();
      if (drct) begin
        #1;
        chk("bdone_pulse", d_bdone, 0);
        tick();
      end
      m_bvalid = 1'b0;
    end
    chk("beats", b, int'(el) + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    vecs[0] = '{1, 1, 0, 8'd1, 0};
    vecs[1] = '{0, 0, 0, 8'd0, 1};
    vecs[2] = '{1, 1, 1, 8'd2, 0};
    vecs[3] = '{0, 0, 0, 8'd0, 1};
    n_vec = 4;
`else
    vecs[0] = '{1, 1, 0, 8'd1, 1};
    vecs[1] = '{0, 1, 1, 8'd2, 1};
    vecs[2] = '{0, 0, 0, 8'd0, 0};
    vecs[3] = '{0, 0, 0, 8'd0, 0};
    n_vec = 3;
`endif
    rst = 1'b1;
    {i_req, d_req, d_we, d_wvalid, m_ack, m_wready, m_rvalid, m_rlast, m_bvalid} = '0;
    i_addr = '0; i_len = '0; d_addr = '0; d_len = '0; d_wdata = '0; m_rdata = '0;
    #1;
    chk("reset_outs", any_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Stray memory responses while idle.
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF; m_bvalid = 1'b1;
    #1;
    chk("stray_irv", i_rvalid, 0);
    chk("stray_drv", d_rvalid, 0);
    chk("stray_bdone", d_bdone, 0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
    #1;
    chk("stray_idle", any_out, 0);
    tick();

    // I$ eight-beat refill, ack on the second command cycle.
    i_req = 1'b1; i_addr = 32'h1FC0_0000; i_len = 8'd7; i_pend = 1'b1;
    #1;
    chk("i_lat0", m_req, 0);
    tick();
    run_burst(0, 1, 1);
    model_last_d = 0;

    // D$ write, len 3, wready pattern 1,0,1,1,1.
    raise_d(1, 8'd3);
    run_burst(1, 0, 1);
    model_last_d = 1;
    #1;
    chk("w_idle_after", any_out, 0);
    tick();

    // Tie sequences.
    for (int v = 0; v < n_vec; v++) begin
      if (vecs[v].raise_i) raise_i(vecs[v].len);
      if (vecs[v].raise_d) raise_d(vecs[v].d_we, vecs[v].len);
      run_burst(vecs[v].exp_d, 1, 0);
      model_last_d = vecs[v].exp_d;
    end

    // Single-beat D$ read with an I$ request queued behind it.
    raise_d(0, 8'd0);
    #1;
    chk("sb_req0", m_req, 0);
    tick();
    m_ack = 1'b1;
    #1;
    chk("sb_gnt", d_gnt, 1);
    tick();
    m_ack = 1'b0; d_req = 1'b0; d_pend = 1'b0;
    raise_i(8'd2);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h0BAD_F00D;
    #1;
    chk("sb_rvalid", d_rvalid, 1);
    chk("sb_rlast", d_rlast, 1);
    chk("sb_rdata", d_rdata, 32'h0BAD_F00D);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("sb_dead", m_req, 0);
    tick();
    #1;
    chk("sb_next_req", m_req, 1);
    chk("sb_next_addr", m_addr, i_addr);
    model_last_d = 1;
    run_burst(0, 0, 0);
    model_last_d = 0;

    // Randomized traffic against the arbitration model.
    for (int it = 0; it < 40; it++) begin
      bit w;
      if (!i_pend && $urandom_range(0, 1) == 1) raise_i(8'($urandom_range(0, 7)));
      if (!d_pend && $urandom_range(0, 1) == 1)
        raise_d(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
      if (!i_pend && !d_pend) raise_d(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
      w = exp_winner_d();
      run_burst(w, $urandom_range(0, 2), 0);
      model_last_d = w;
    end
    for (int it = 0; it < 2 && (i_pend || d_pend); it++) begin
      bit w;
      w = exp_winner_d();
      run_burst(w, 0, 0);
      model_last_d = w;
    end

    // Reset asserted during the second write beat.
    raise_d(1, 8'd3);
    tick();
    #1;
    chk("rb_req", m_req, 1);
    m_ack = 1'b1;
    #1;
    chk("rb_gnt", d_gnt, 1);
    tick();
    m_ack = 1'b0; d_req = 1'b0; d_pend = 1'b0;
    d_wvalid = 1'b1; d_wdata = 32'h1111_1111; m_wready = 1'b1;
    #1;
    chk("rb_beat1", d_wready, 1);
    tick();
    d_wdata = 32'h2222_2222;
    #1;
    chk("rb_beat2_valid", m_wvalid, 1);
    chk("rb_beat2_wlast", m_wlast, 0);
    rst = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    #1;
    chk("rb_outs_zero", any_out, 0);
    tick();
    #1;
    chk("rb_outs_held", any_out, 0);
    rst = 1'b0;
    {d_wvalid, m_wready, m_rvalid, m_bvalid} = '0;
    model_last_d = 1;
    tick();
    #1;
    chk("rb_idle", any_out, 0);
    tick();
    raise_i(8'd3);
    run_burst(0, 0, 0);
    model_last_d = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
